// File: rtl/enigma_pkg.sv
// Shared constants and FSM state encoding for the enigma feeder.
package enigma_pkg;

  localparam int ROTOR_SIZE  = 64;
  localparam int NUM_ROTORS  = 3;
  localparam int SYM_W       = 6;
  localparam int TABLE_DEPTH = ROTOR_SIZE * NUM_ROTORS;
  localparam int IDX_W       = 8;
  localparam int GAP_CYCLES  = 3;
  localparam int GAP_W       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_CRYPT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/enigma_feeder_if.sv
// Upstream symbol stream plus the control bus toward the enigma core.
interface enigma_feeder_if;
  import enigma_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [SYM_W-1:0] in_data;
  logic             in_last;

  logic             load;
  logic [IDX_W-1:0] load_idx;
  logic [SYM_W-1:0] code_in;
  logic             encrypt;
  logic             crypt_mode;

  // Environment side: drives the stream, observes the core bus.
  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, load, load_idx, code_in, encrypt, crypt_mode
  );

  // Feeder side.
  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, load, load_idx, code_in, encrypt, crypt_mode
  );

endinterface

// File: rtl/feeder_out_reg.sv
// Output register stage toward the core: strobes last one cycle, index and
// symbol hold their value through bubbles.
module feeder_out_reg
  import enigma_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_stb_i,
  input  logic             enc_stb_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [SYM_W-1:0] data_i,
  output logic             load_o,
  output logic             encrypt_o,
  output logic [IDX_W-1:0] load_idx_o,
  output logic [SYM_W-1:0] code_in_o
);

  logic             load_q, load_d;
  logic             enc_q, enc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SYM_W-1:0] code_q, code_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    load_d = load_stb_i;
    enc_d  = enc_stb_i;
    idx_d  = idx_q;
    code_d = code_q;
    if (load_stb_i) begin
      idx_d  = idx_i;
      code_d = data_i;
    end else if (enc_stb_i) begin
      code_d = data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q <= 1'b0;
      enc_q  <= 1'b0;
      idx_q  <= '0;
      code_q <= '0;
    end else begin
      load_q <= load_d;
      enc_q  <= enc_d;
      idx_q  <= idx_d;
      code_q <= code_d;
    end
  end

  assign load_o     = load_q;
  assign encrypt_o  = enc_q;
  assign load_idx_o = idx_q;
  assign code_in_o  = code_q;

endmodule

// File: rtl/enigma_feeder.sv
// Feeder FSM: rotor-table load, idle gap, then per-symbol encrypt strobes.
// Optional FEEDER_STATS_EN adds a saturating text-symbol counter (sym_cnt).
module enigma_feeder
  import enigma_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic              mode_in,
  enigma_feeder_if.slave    bus,
  output logic              busy,
  output logic              msg_done,
  output logic              err_last
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]       sym_cnt
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_DEPTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic             done_q;

  logic in_ready;
  logic accept;
  logic start_go;
  logic load_stb;
  logic enc_stb;

  assign in_ready = (state_q == ST_LOAD) || (state_q == ST_CRYPT);
  assign accept   = bus.in_valid & in_ready;
  assign start_go = (state_q == ST_IDLE) & start;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    mode_d   = mode_q;
    err_d    = err_q;
    load_stb = 1'b0;
    enc_stb  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          mode_d  = mode_in;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          load_stb = 1'b1;
          if (bus.in_last) err_d = 1'b1;
          // The index stops at the last entry rather than wrapping.
          if (cnt_q == LAST_IDX) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_CRYPT;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      ST_CRYPT: begin
        if (accept) begin
          enc_stb = 1'b1;
          if (bus.in_last) state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      done_q  <= (state_q == ST_DONE);
    end
  end

  feeder_out_reg u_out (
    .clk        (clk),
    .rst        (srst),
    .load_stb_i (load_stb),
    .enc_stb_i  (enc_stb),
    .idx_i      (cnt_q),
    .data_i     (bus.in_data),
    .load_o     (bus.load),
    .encrypt_o  (bus.encrypt),
    .load_idx_o (bus.load_idx),
    .code_in_o  (bus.code_in)
  );

  assign bus.in_ready   = in_ready;
  assign bus.crypt_mode = mode_q;
  assign busy           = (state_q != ST_IDLE);
  assign msg_done       = done_q;
  assign err_last       = err_q;

`ifdef FEEDER_STATS_EN
  logic [15:0] sym_cnt_q, sym_cnt_d;

  always_comb begin
    sym_cnt_d = sym_cnt_q;
    if (start_go)                            sym_cnt_d = '0;
    else if (enc_stb && sym_cnt_q != 16'hFFFF) sym_cnt_d = sym_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) sym_cnt_q <= '0;
    else      sym_cnt_q <= sym_cnt_d;
  end

  assign sym_cnt = sym_cnt_q;
`else
  // Statistics counter not built; start_go only feeds it.
  logic unused_start_go;
  assign unused_start_go = start_go;
`endif

endmodule

// File: tb/tb_enigma_feeder.sv
// Scoreboard bench for enigma_feeder: a message-level model queues the expected
// core transactions, a negedge monitor pops and compares them.
module tb_enigma_feeder;
  import enigma_pkg::*;

  logic clk = 1'b0;
  logic srst = 1'b1;
  logic start = 1'b0;
  logic mode_in = 1'b0;
  logic busy, msg_done, err_last;
`ifdef FEEDER_STATS_EN
  logic [15:0] sym_cnt;
`endif

  enigma_feeder_if bus ();

  enigma_feeder dut (
    .clk      (clk),
    .srst     (srst),
    .start    (start),
    .mode_in  (mode_in),
    .bus      (bus.slave),
    .busy     (busy),
    .msg_done (msg_done),
    .err_last (err_last)
`ifdef FEEDER_STATS_EN
    ,
    .sym_cnt  (sym_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit enc;
    int idx;
    int data;
    bit mode;
    bit err;
    bit last;
    bit first;
    int cnt;
  } item_t;

  item_t sb[$];
  int    gap_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    last_load_cyc = 0;
  int    done_cyc = -1;
  bit    done_mode, done_err;
  int    done_cnt;
  item_t mon_it;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Monitor: every strobe toward the core must match the next queued transaction.
  always @(negedge clk) begin
    cyc++;
    if (!srst) begin
      if (bus.load || bus.encrypt) begin
        check("load_encrypt_exclusive", bus.load & bus.encrypt, 0);
        if (sb.size() == 0) begin
          timeout("unexpected_strobe");
        end else begin
          mon_it = sb.pop_front();
          check("strobe_kind_encrypt", bus.encrypt, mon_it.enc);
          check("load_idx", bus.load_idx, mon_it.idx);
          check("code_in", bus.code_in, mon_it.data);
          check("crypt_mode", bus.crypt_mode, mon_it.mode);
          check("err_last", err_last, mon_it.err);
          check("busy_active", busy, 1);
          if (!mon_it.enc) last_load_cyc = cyc;
          if (mon_it.enc && mon_it.first && gap_q.size() > 0)
            check("gap_cycles", cyc - last_load_cyc - 1, gap_q.pop_front());
          if (mon_it.last) begin
            done_cyc  = cyc + 1;
            done_mode = mon_it.mode;
            done_err  = mon_it.err;
            done_cnt  = mon_it.cnt;
          end
        end
      end
      if (msg_done || cyc == done_cyc) begin
        check("msg_done_timing", msg_done, cyc == done_cyc);
        if (msg_done) begin
          check("busy_at_done", busy, 0);
          check("err_last_at_done", err_last, done_err);
          check("crypt_mode_at_done", bus.crypt_mode, done_mode);
`ifdef FEEDER_STATS_EN
          check("sym_cnt_at_done", sym_cnt, done_cnt);
`endif
        end
        done_cyc = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Presents one symbol after 'bubbles' idle cycles and holds it until accepted.
  task automatic send(input logic [SYM_W-1:0] d, input bit last, input int bubbles);
    bit acc = 1'b0;
    int n = 0;
    bus.in_valid = 1'b0;
    repeat (bubbles) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      n++;
    end
    if (!acc) timeout("accept");
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    if (busy) timeout("wait_idle");
  endtask

  // bub_mode: 0 back-to-back, 1 one idle cycle per symbol, 2 random 0..4.
  task automatic run_msg(input bit mode, input int n_text, input int early,
                         input int bub_mode, input int abort_at, input bit ghost);
    logic [SYM_W-1:0] tbl[TABLE_DEPTH];
    logic [SYM_W-1:0] txt[$];
    int    bub[$];
    int    n_tbl;
    int    b;
    item_t it;

    wait_idle();
    n_tbl = (abort_at >= 0) ? abort_at + 1 : TABLE_DEPTH;
    for (int i = 0; i < TABLE_DEPTH + n_text; i++) begin
      b = (bub_mode == 0) ? 0 : (bub_mode == 1) ? 1 : int'($urandom_range(0, 4));
      bub.push_back(b);
    end
    for (int i = 0; i < TABLE_DEPTH; i++) tbl[i] = SYM_W'($urandom_range(0, 63));
    for (int j = 0; j < n_text; j++) txt.push_back(SYM_W'($urandom_range(0, 63)));

    for (int i = 0; i < n_tbl; i++) begin
      it = '{enc: 1'b0, idx: i, data: int'(tbl[i]), mode: mode,
             err: (early >= 0 && i >= early), last: 1'b0, first: 1'b0, cnt: 0};
      sb.push_back(it);
    end
    if (abort_at < 0) begin
      for (int j = 0; j < n_text; j++) begin
        it = '{enc: 1'b1, idx: TABLE_DEPTH - 1, data: int'(txt[j]), mode: mode,
               err: (early >= 0), last: (j == n_text - 1), first: (j == 0), cnt: j + 1};
        sb.push_back(it);
      end
      gap_q.push_back((bub[TABLE_DEPTH] > GAP_CYCLES) ? bub[TABLE_DEPTH] : GAP_CYCLES);
    end

    mode_in = mode;
    start   = 1'b1;
    tick();
    mode_in = !mode;
    check("err_last_cleared_on_start", err_last, 0);
    check("busy_after_start", busy, 1);
`ifdef FEEDER_STATS_EN
    check("sym_cnt_cleared_on_start", sym_cnt, 0);
`endif

    for (int i = 0; i < n_tbl; i++) send(tbl[i], (i == early), bub[i]);

    if (abort_at >= 0) begin
      @(negedge clk);
      #2;
      srst = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      check("abort_load", bus.load, 0);
      check("abort_encrypt", bus.encrypt, 0);
      check("abort_busy", busy, 0);
      check("abort_in_ready", bus.in_ready, 0);
      check("abort_load_idx", bus.load_idx, 0);
      check("abort_crypt_mode", bus.crypt_mode, 0);
      repeat (2) @(negedge clk);
      srst = 1'b0;
      tick();
      return;
    end

    for (int j = 0; j < n_text; j++) begin
      if (ghost && j == 5) start = 1'b1;
      send(txt[j], (j == n_text - 1), bub[TABLE_DEPTH + j]);
    end
    wait_idle();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    #23;
    srst = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_load", bus.load, 0);
    check("rst_load_idx", bus.load_idx, 0);
    check("rst_code_in", bus.code_in, 0);
    check("rst_encrypt", bus.encrypt, 0);
    check("rst_crypt_mode", bus.crypt_mode, 0);
    check("rst_busy", busy, 0);
    check("rst_msg_done", msg_done, 0);
    check("rst_err_last", err_last, 0);
    tick();

    run_msg(1'b0, 24, -1, 0, -1, 1'b0);
    run_msg(1'b1, 24, -1, 1, -1, 1'b1);
    run_msg(1'b0, 10, 50, 2, -1, 1'b0);
    run_msg(1'b1, 5, -1, 0, 100, 1'b0);
    run_msg(1'b0, 8, -1, 0, -1, 1'b0);
    for (int k = 0; k < 3; k++)
      run_msg(1'($urandom_range(0, 1)), int'($urandom_range(1, 30)),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TABLE_DEPTH - 1)) : -1,
              2, -1, 1'b0);

    repeat (5) tick();
    check("scoreboard_drained", sb.size(), 0);
    check("gap_queue_drained", gap_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/enigma_feeder.md
Name: enigma_feeder

Overview:
- Upstream stage of enigma_part2: turns one valid/ready symbol stream into that core's control sequence.
- Sequence per message: rotor-table load (load/load_idx/code_in), a mandatory idle gap, then per-symbol encrypt strobes.
- One message = 192 table symbols (rotors A, B, C, 64 each) followed by N text symbols ending with in_last.
- All outputs toward the core are registered.

Parameters:
- TABLE_DEPTH, 192, number of rotor-table symbols (3 x 64)
- IDX_W, 8, width of load_idx
- SYM_W, 6, symbol width
- GAP_CYCLES, 3, idle cycles between table load end and first encrypt (minimum 1)

Ports:
- clk  in  1  clock, rising edge
- srst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle pulse; begins a message from IDLE
- mode_in  in  1  crypt mode (0 encrypt, 1 decrypt), sampled on start
- in_valid  in  1  upstream symbol valid
- in_ready  out  1  feeder accepts a symbol this cycle
- in_data  in  SYM_W  upstream symbol
- in_last  in  1  marks final text symbol; qualified by in_valid & in_ready
- load  out  1  to core: table write strobe
- load_idx  out  IDX_W  to core: table index 0..191
- code_in  out  SYM_W  to core: table entry or text symbol
- encrypt  out  1  to core: one text symbol presented this cycle
- crypt_mode  out  1  to core: latched mode
- busy  out  1  high in any state other than IDLE
- msg_done  out  1  one-cycle pulse after the last text symbol has been issued
- err_last  out  1  sticky; in_last seen during LOAD; cleared on start

Behaviour:
- Reset values: in_ready=0, load=0, load_idx=0, code_in=0, encrypt=0, crypt_mode=0, busy=0, msg_done=0, err_last=0. FSM goes to IDLE and the index counter is cleared.
- Reset mid-message aborts immediately. The core sees load=0 and encrypt=0 from the reset edge onward.
- Accept condition: a symbol is accepted when in_valid & in_ready.
- Latency: an accept at edge t drives the core outputs at t+1. The outputs are valid for exactly one cycle.
- FSM states: IDLE, LOAD, GAP, CRYPT, DONE.
- IDLE:
  - in_ready=0.
  - start -> LOAD; latch crypt_mode=mode_in; cnt=0; clear err_last.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1.
  - Each accept issues load=1, load_idx=cnt, code_in=in_data, then cnt++.
  - No accept issues load=0; load_idx and code_in hold their values (bubbles allowed).
  - in_last on an accept in LOAD: sets err_last; the symbol is still loaded.
  - Accept with cnt==TABLE_DEPTH-1 -> GAP; gap counter=0.
- GAP:
  - in_ready=0, load=0, encrypt=0.
  - Lasts exactly GAP_CYCLES cycles, then -> CRYPT.
- CRYPT:
  - in_ready=1.
  - Each accept issues encrypt=1, code_in=in_data for one cycle.
  - No accept issues encrypt=0 (the core's rotors must not step).
  - Accept with in_last -> DONE; in_ready drops in the same cycle the transition registers.
- DONE:
  - msg_done=1 for one cycle; in_ready=0; -> IDLE.
- Width: cnt is IDX_W bits. TABLE_DEPTH must be no greater than 2^IDX_W. cnt never wraps within a message.
- crypt_mode is held constant from start to the next start.

Optional Feature:
- Macro: FEEDER_STATS_EN
- Defined: adds output sym_cnt (16 bits), reset 0, cleared on start, incremented on every CRYPT accept. It saturates at 0xFFFF.
- Undefined: no port and no logic; behaviour is otherwise identical.

Decomposition:
- Package enigma_pkg holds:
  - state encoding (IDLE..DONE)
  - ROTOR_SIZE=64
  - NUM_ROTORS=3
  - SYM_W=6
  - TABLE_DEPTH=ROTOR_SIZE*NUM_ROTORS
- One sub-module, feeder_out_reg: registers load/load_idx/code_in/encrypt from the accept strobe and handles the hold-on-bubble rule.
- The FSM and counters stay in the top level.

Test Plan:
- Full message, no bubbles:
  - Stimulus: start, mode_in=0, then 192 table symbols and 24 text symbols, last one with in_last.
  - Response: load pulses with load_idx 0..191 on consecutive cycles; exactly 3 cycles with load=encrypt=0; 24 consecutive encrypt pulses; msg_done one cycle after the final encrypt.
- Bubbles:
  - Stimulus: in_valid toggled 1,0,1,0 during LOAD and CRYPT.
  - Response: load/encrypt pulse only on accepts; load_idx increments only on accepts; 192 loads and 24 encrypts total.
- Decrypt mode latch:
  - Stimulus: start with mode_in=1, then mode_in changed to 0 mid-message.
  - Response: crypt_mode stays 1 through DONE.
- Early in_last:
  - Stimulus: in_last asserted on table symbol 50.
  - Response: err_last=1 sticky; loading continues to index 191; err_last clears on the next start.
- Reset mid-operation:
  - Stimulus: srst asserted at load_idx=100.
  - Response: same cycle, load=0, busy=0, in_ready=0. The next start begins from load_idx=0.
- Stats (FEEDER_STATS_EN defined):
  - Stimulus: 24 text symbols.
  - Response: sym_cnt=24 at msg_done; sym_cnt=0 after the next start.
